dual_issue_scheduler: RTL and testbench
=======================================

Name: dual_issue_scheduler

Overview:
Instruction buffer and issue controller in front of the two ALU issue slots. It accepts fetched instructions in order into a small FIFO. Each cycle it issues either the head instruction alone or the head pair together. A pair is issued when the second instruction is independent of the first and is supported by the slot-1 ALU. It also counts dual-issue cycles for performance monitoring.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2
CNT_W, 16, width of the dual-issue performance counter

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  fetch presents in_ins
in_ready  output  1  FIFO can accept an instruction this cycle
in_ins  input  32  fetched instruction
stall  input  1  downstream cannot accept; hold issue registers and FIFO head
flush  input  1  discard all buffered and issued-but-held instructions
iss0_valid  output  1  slot 0 holds a valid instruction
iss0_ins  output  32  slot 0 instruction (older)
iss1_valid  output  1  slot 1 holds a valid instruction
iss1_ins  output  32  slot 1 instruction (younger; ALU R-type only)
dual_cnt  output  CNT_W  saturating count of cycles in which a pair was issued

Behaviour:
- Reset (reset_n low, asynchronous): FIFO empty (count=0, pointers 0); iss0_valid=0, iss1_valid=0, iss0_ins=0, iss1_ins=0, dual_cnt=0. in_ready=1 while count=0.
- in_ready = (count < DEPTH), combinational from registered count only. It does not depend on a same-cycle pop.
- Push: occurs at the clock edge when in_valid & in_ready & !flush. Entries retain arrival order.
- Pairing rule for A = head and B = head+1:
  - opcode(A) is 0110011 or 0010011, and opcode(B) is 0110011.
  - rd(A) is different from rs1(B), rs2(B) and rd(B).
  - B's {funct3, funct7} is one of: {000, 0000000} add, {000, 0100000} sub, {111, 0000000} and, {110, 0000000} or, {010, 0000000} slt.
- Issue decision, evaluated each cycle when !stall & !flush:
  - count>=2 and the pair is pairable: pop 2; iss0_ins<=A, iss1_ins<=B; both valid. dual_cnt increments and saturates at all-ones.
  - else if count>=1: pop 1; iss0_ins<=A, iss0_valid=1, iss1_valid=0.
  - else: iss0_valid=0, iss1_valid=0. Instruction registers keep their old values.
- Issue latency: an instruction pushed at edge N can issue at edge N+1 at the earliest. There is no FIFO bypass.
- stall=1 (and flush=0): issue registers, valids and FIFO head are held with no pop. A push is still accepted if in_ready. dual_cnt is held.
- flush=1: takes priority over stall and push. At the next edge count=0, both valids=0, and any in_valid that cycle is dropped. dual_cnt is not cleared.
- Simultaneous push and pop: allowed. count_next = count + push - pops. Pointers wrap modulo DEPTH.
- Full (count=DEPTH): in_ready=0. A pop that cycle does not enable the push; in_ready rises the following cycle.
- Never issue B ahead of A. Never issue slot 1 without slot 0.
- Reset asserted mid-operation: immediate clear as at reset. Outputs are valid from the first edge after reset_n rises.

Test Plan:
- Independent pair: push 0x003100B3 (add x1,x2,x3) then 0x00628233 (add x4,x5,x6), no stall -> one cycle with iss0_ins=0x003100B3, iss1_ins=0x00628233, both valid; dual_cnt=1.
- RAW dependency: push 0x003100B3 then 0x006082B3 (add x5,x1,x6) -> issued in two consecutive cycles, each with iss1_valid=0; dual_cnt=0.
- Non-ALU head: push 0x00012083 (lw x1,0(x2)) then 0x00628233 -> two single issues in order.
- Full/backpressure: stall=1, push 5 instructions with in_valid held high -> in_ready=0 after 4 pushes and count=4. Release stall -> in-order drain, and the 5th instruction is accepted one cycle after the first pop.
- Flush during stall: 3 entries buffered, iss0_valid=1, assert flush with in_valid=1 -> next cycle valids=0, in_ready=1, FIFO empty, the pushed instruction is not issued later, dual_cnt unchanged.
- Async reset mid-stream: drop reset_n between clock edges -> all outputs go to reset values immediately, without waiting for a clock edge. Counter saturation: preload traffic to reach 0xFFFF -> a further pair keeps dual_cnt at 0xFFFF.

Source files
------------

// File: rtl/dual_issue_scheduler.sv
// dual_issue_scheduler
//   In-order instruction buffer feeding two ALU issue slots. Each cycle the
//   head instruction issues alone, or the head pair issues together when the
//   younger one is an independent R-type op the slot-1 ALU supports.
//   Counts dual-issue cycles (saturating) for performance monitoring.
// Ports:
//   clk, reset_n            clock (rising edge), async active-low reset
//   in_valid/in_ready/in_ins fetch handshake into the buffer
//   stall                   hold issue registers and buffer head
//   flush                   drop everything buffered and held in the slots
//   iss0_valid/iss0_ins     slot 0 (older instruction)
//   iss1_valid/iss1_ins     slot 1 (younger instruction)
//   dual_cnt                saturating count of paired issue cycles
module dual_issue_scheduler #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_ins,
  input  logic             stall,
  input  logic             flush,
  output logic             iss0_valid,
  output logic [31:0]      iss0_ins,
  output logic             iss1_valid,
  output logic [31:0]      iss1_ins,
  output logic [CNT_W-1:0] dual_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic [31:0]   head;
  logic [31:0]   nxt;
  logic          push;
  logic          do_pair;
  logic          do_one;
  logic [CW-1:0] pops;

  // Slot 1 takes only independent add/sub/and/or/slt behind an ALU-class head.
  function automatic logic pairable(input logic [31:0] a, input logic [31:0] b);
    logic a_ok;
    logic b_ok;
    logic indep;
    logic fn_ok;
    a_ok  = (a[6:0] == 7'b0110011) || (a[6:0] == 7'b0010011);
    b_ok  = (b[6:0] == 7'b0110011);
    indep = (a[11:7] != b[19:15]) && (a[11:7] != b[24:20]) && (a[11:7] != b[11:7]);
    case ({b[14:12], b[31:25]})
      10'b000_0000000,
      10'b000_0100000,
      10'b111_0000000,
      10'b110_0000000,
      10'b010_0000000: fn_ok = 1'b1;
      default:         fn_ok = 1'b0;
    endcase
    return a_ok && b_ok && indep && fn_ok;
  endfunction

  assign in_ready = (count < FULL);
  assign head     = mem[rd_ptr];
  assign nxt      = mem[rd_ptr + AW'(1)];

  always_comb begin
    push    = in_valid && in_ready && !flush;
    do_pair = 1'b0;
    do_one  = 1'b0;
    pops    = '0;
    if (!stall && !flush) begin
      if (count >= CW'(2) && pairable(head, nxt)) begin
        do_pair = 1'b1;
        pops    = CW'(2);
      end else if (count >= CW'(1)) begin
        do_one = 1'b1;
        pops   = CW'(1);
      end
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_ins;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      iss0_valid <= 1'b0;
      iss1_valid <= 1'b0;
      iss0_ins   <= '0;
      iss1_ins   <= '0;
      dual_cnt   <= '0;
    end else if (flush) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      iss0_valid <= 1'b0;
      iss1_valid <= 1'b0;
    end else begin
      // Pointer width is log2(DEPTH), so truncating the add wraps modulo DEPTH.
      count  <= count + CW'(push) - pops;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pops);
      if (!stall) begin
        iss0_valid <= do_pair || do_one;
        iss1_valid <= do_pair;
        if (do_pair || do_one) iss0_ins <= head;
        if (do_pair) iss1_ins <= nxt;
        if (do_pair && dual_cnt != '1) dual_cnt <= dual_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dual_issue_scheduler.sv
module tb_dual_issue_scheduler;

  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_ins = '0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic          iss0_valid;
  logic [31:0]   iss0_ins;
  logic          iss1_valid;
  logic [31:0]   iss1_ins;
  logic [CW-1:0] dual_cnt;

  dual_issue_scheduler #(.DEPTH(4), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ins(in_ins), .stall(stall), .flush(flush),
    .iss0_valid(iss0_valid), .iss0_ins(iss0_ins),
    .iss1_valid(iss1_valid), .iss1_ins(iss1_ins), .dual_cnt(dual_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          pair;
  } vec_t;

  typedef struct {
    bit          v1;
    logic [31:0] i0;
    logic [31:0] i1;
  } exp_t;

  vec_t vt[12];
  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_dual = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_issue(input string name);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({name, "_unexpected_issue"}, iss0_ins, 32'hxxxx_xxxx);
      return;
    end
    e = sbq.pop_front();
    chk({name, "_iss0_ins"}, iss0_ins, e.i0);
    chk({name, "_iss1_valid"}, {31'b0, iss1_valid}, {31'b0, e.v1});
    if (e.v1) chk({name, "_iss1_ins"}, iss1_ins, e.i1);
  endtask

  task automatic drain(input string name);
    int budget = 20;
    in_valid = 1'b0;
    stall    = 1'b0;
    while (sbq.size() > 0 && budget > 0) begin
      tick();
      budget--;
      if (iss0_valid) check_issue(name);
    end
    if (sbq.size() > 0) begin
      chk({name, "_drain_timeout"}, sbq.size(), 0);
      sbq.delete();
    end
    tick();
    chk({name, "_idle_valids"}, {30'b0, iss0_valid, iss1_valid}, 32'd0);
  endtask

  task automatic run_vec(input string name, input logic [31:0] a, input logic [31:0] b, input bit pair);
    exp_t e;
    stall    = 1'b1;
    in_valid = 1'b1;
    in_ins   = a;
    chk({name, "_ready_a"}, {31'b0, in_ready}, 32'd1);
    tick();
    in_ins = b;
    tick();
    in_valid = 1'b0;
    if (pair) begin
      e = '{1'b1, a, b};
      sbq.push_back(e);
      exp_dual = (exp_dual == 255) ? 255 : exp_dual + 1;
    end else begin
      e = '{1'b0, a, 32'h0};
      sbq.push_back(e);
      e = '{1'b0, b, 32'h0};
      sbq.push_back(e);
    end
    drain(name);
    chk({name, "_dual_cnt"}, {24'b0, dual_cnt}, exp_dual);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    vt[0]  = '{32'h003100B3, 32'h00628233, 1'b1};  // add, add independent
    vt[1]  = '{32'h003100B3, 32'h006082B3, 1'b0};  // RAW on rs1
    vt[2]  = '{32'h00012083, 32'h00628233, 1'b0};  // lw head
    vt[3]  = '{32'h00510093, 32'h00628233, 1'b1};  // addi head
    vt[4]  = '{32'h003100B3, 32'h006280B3, 1'b0};  // WAW
    vt[5]  = '{32'h003100B3, 32'h40628233, 1'b1};  // sub
    vt[6]  = '{32'h003100B3, 32'h02628233, 1'b0};  // mul: unsupported
    vt[7]  = '{32'h003100B3, 32'h0062C233, 1'b0};  // xor: unsupported
    vt[8]  = '{32'h003100B3, 32'h0062F233, 1'b1};  // and
    vt[9]  = '{32'h003100B3, 32'h0062A233, 1'b1};  // slt
    vt[10] = '{32'h003100B3, 32'h00528213, 1'b0};  // addi in slot 1
    vt[11] = '{32'h003100B3, 32'h00128233, 1'b0};  // RAW on rs2

    #3;
    chk("rst_iss0_valid", {31'b0, iss0_valid}, 32'd0);
    chk("rst_iss1_valid", {31'b0, iss1_valid}, 32'd0);
    chk("rst_iss0_ins", iss0_ins, 32'd0);
    chk("rst_iss1_ins", iss1_ins, 32'd0);
    chk("rst_dual_cnt", {24'b0, dual_cnt}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    #4 reset_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) run_vec($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].pair);

    // Full / backpressure: 5 loads under stall, 5th held until after first pop.
    stall    = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_ins = 32'h1000_0003 + (k << 20);
      chk($sformatf("full_ready%0d", k), {31'b0, in_ready}, 32'd1);
      e = '{1'b0, in_ins, 32'h0};
      sbq.push_back(e);
      tick();
    end
    in_ins = 32'h1040_0003;
    chk("full_ready_low", {31'b0, in_ready}, 32'd0);
    tick();
    chk("full_ready_held", {31'b0, in_ready}, 32'd0);
    chk("full_no_issue", {31'b0, iss0_valid}, 32'd0);
    stall = 1'b0;
    tick();
    chk("full_first_pop_valid", {31'b0, iss0_valid}, 32'd1);
    if (iss0_valid) check_issue("full_pop0");
    chk("full_ready_after_pop", {31'b0, in_ready}, 32'd1);
    e = '{1'b0, 32'h1040_0003, 32'h0};
    sbq.push_back(e);
    tick();
    in_valid = 1'b0;
    if (iss0_valid) check_issue("full_pop1");
    drain("full");

    // Flush while stalled with buffered entries and a held slot 0.
    in_valid = 1'b1;
    in_ins   = 32'h2000_0003;
    tick();
    in_ins = 32'h2010_0003;
    tick();
    chk("fl_iss0_valid", {31'b0, iss0_valid}, 32'd1);
    chk("fl_iss0_ins", iss0_ins, 32'h2000_0003);
    stall  = 1'b1;
    in_ins = 32'h2020_0003;
    tick();
    in_ins = 32'h2030_0003;
    tick();
    chk("fl_held_ins", iss0_ins, 32'h2000_0003);
    flush  = 1'b1;
    in_ins = 32'h2040_0003;
    tick();
    flush    = 1'b0;
    stall    = 1'b0;
    in_valid = 1'b0;
    chk("fl_valids", {30'b0, iss0_valid, iss1_valid}, 32'd0);
    chk("fl_in_ready", {31'b0, in_ready}, 32'd1);
    chk("fl_dual_cnt", {24'b0, dual_cnt}, exp_dual);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("fl_no_issue%0d", k), {31'b0, iss0_valid}, 32'd0);
    end

    // Async reset between edges.
    stall    = 1'b1;
    in_valid = 1'b1;
    in_ins   = 32'h003100B3;
    tick();
    in_ins = 32'h00628233;
    tick();
    in_valid = 1'b0;
    stall    = 1'b0;
    tick();
    chk("ar_pre_valid", {31'b0, iss1_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_valids", {30'b0, iss0_valid, iss1_valid}, 32'd0);
    chk("ar_iss0_ins", iss0_ins, 32'd0);
    chk("ar_iss1_ins", iss1_ins, 32'd0);
    chk("ar_dual_cnt", {24'b0, dual_cnt}, 32'd0);
    chk("ar_in_ready", {31'b0, in_ready}, 32'd1);
    exp_dual = 0;
    tick();
    reset_n = 1'b1;
    tick();
    run_vec("post_rst", 32'h003100B3, 32'h00628233, 1'b1);

    // Counter saturation.
    for (int g = 0; g < 300 && exp_dual != 255; g++) begin
      stall    = 1'b1;
      in_valid = 1'b1;
      in_ins   = 32'h003100B3;
      tick();
      in_ins = 32'h00628233;
      tick();
      in_valid = 1'b0;
      stall    = 1'b0;
      tick();
      exp_dual++;
    end
    chk("sat_reach", {24'b0, dual_cnt}, 32'd255);
    run_vec("sat_hold", 32'h003100B3, 32'h00628233, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
